// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: configuration controller that streams one bit per chain
// into the fabric's ccff heads and then signals cfg_done once the chains settle.
//
// Optional feature macro: CCFF_LOADER_CRC_EN
//   Adds port crc_expected[15:0] and checks a CRC-16-CCITT (poly 0x1021,
//   init 0xFFFF, MSB first, data zero-extended to whole bytes) before DONE.
//
// Flow: IDLE -start-> LOAD -CHAIN_LEN words-> SETTLE -SETTLE_CYCLES-> DONE
//       LOAD -stall timeout-> ERROR (also SETTLE -CRC mismatch-> ERROR)
//       abort returns to IDLE from anywhere; start re-enters LOAD from
//       IDLE, DONE or ERROR.
module ccff_bitstream_loader #(
   parameter int NUM_CHAINS    = 10,
   parameter int CHAIN_LEN     = 4096,
   parameter int CNT_W         = 16,
   parameter int SETTLE_CYCLES = 4,
   parameter int TIMEOUT       = 1024
) (
   input  logic                  prog_clock,
   input  logic                  global_resetn,
   input  logic                  start,
   input  logic                  abort,
   input  logic [NUM_CHAINS-1:0] bs_data,
   input  logic                  bs_valid,
`ifdef CCFF_LOADER_CRC_EN
   input  logic [15:0]           crc_expected,
`endif
   output logic                  bs_ready,
   output logic [NUM_CHAINS-1:0] ccff_head,
   output logic                  ccff_shift_en,
   output logic                  cfg_busy,
   output logic                  cfg_done,
   output logic                  cfg_err,
   output logic [CNT_W-1:0]      word_count
);

   // Stall counter only needs to reach TIMEOUT; keep at least one bit so the
   // TIMEOUT=0 (disabled) build still has a legal vector.
   localparam int ST_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   // Settle counter runs 0 .. SETTLE_CYCLES-1.
   localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(CHAIN_LEN - 1);
   localparam logic [ST_W-1:0]  STALL_LIMIT = ST_W'(TIMEOUT);
   localparam logic [SC_W-1:0]  SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETTLE = 3'd2,
      DONE   = 3'd3,
      ERROR  = 3'd4
   } state_t;

   state_t                  state, state_nxt;
   logic [NUM_CHAINS-1:0]   head_nxt;
   logic                    shift_nxt;
   logic                    done_nxt;
   logic                    err_nxt;
   logic [CNT_W-1:0]        wc_nxt;
   logic [ST_W-1:0]         stall_cnt, stall_nxt;
   logic [SC_W-1:0]         settle_cnt, settle_nxt;
   logic                    hs;

`ifdef CCFF_LOADER_CRC_EN
   localparam int CRC_BITS = ((NUM_CHAINS + 7) / 8) * 8;

   logic [15:0] crc, crc_nxt;

   // One word of CRC-16-CCITT, bit-serial, most significant bit first.
   function automatic logic [15:0] crc_word(input logic [15:0]         c,
                                            input logic [CRC_BITS-1:0] d);
      logic [15:0] r;
      logic        fb;
      r = c;
      for (int i = CRC_BITS - 1; i >= 0; i--) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return r;
   endfunction
`endif

   // Ready is a pure function of state so the source sees it without delay.
   assign bs_ready = (state == LOAD);
   assign hs       = bs_valid & bs_ready;
   assign cfg_busy = (state == LOAD) || (state == SETTLE);

   // Next-state and next-register values; defaults hold everything except
   // the shift strobe, which is a single-cycle pulse per accepted word.
   always_comb begin
      state_nxt  = state;
      head_nxt   = ccff_head;
      shift_nxt  = 1'b0;
      done_nxt   = cfg_done;
      err_nxt    = cfg_err;
      wc_nxt     = word_count;
      stall_nxt  = stall_cnt;
      settle_nxt = settle_cnt;
`ifdef CCFF_LOADER_CRC_EN
      crc_nxt    = crc;
`endif
      if (abort) begin
         // Error flag is deliberately kept so software can still see why.
         state_nxt = IDLE;
         done_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state_nxt = LOAD;
                  wc_nxt    = '0;
                  err_nxt   = 1'b0;
                  done_nxt  = 1'b0;
                  stall_nxt = '0;
`ifdef CCFF_LOADER_CRC_EN
                  crc_nxt   = 16'hFFFF;
`endif
               end
            end
            LOAD: begin
               if (hs) begin
                  head_nxt  = bs_data;
                  shift_nxt = 1'b1;
                  wc_nxt    = word_count + 1'b1;
                  stall_nxt = '0;
`ifdef CCFF_LOADER_CRC_EN
                  crc_nxt   = crc_word(crc, CRC_BITS'(bs_data));
`endif
                  if (word_count == LAST_WORD) begin
                     state_nxt  = SETTLE;
                     settle_nxt = '0;
                  end
               end else if (TIMEOUT > 0) begin
                  stall_nxt = stall_cnt + 1'b1;
                  if (stall_nxt >= STALL_LIMIT) begin
                     state_nxt = ERROR;
                     err_nxt   = 1'b1;
                  end
               end
            end
            SETTLE: begin
               if (settle_cnt == SETTLE_LAST) begin
`ifdef CCFF_LOADER_CRC_EN
                  if (crc == crc_expected) begin
                     state_nxt = DONE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = ERROR;
                     err_nxt   = 1'b1;
                  end
`else
                  state_nxt = DONE;
                  done_nxt  = 1'b1;
`endif
               end else begin
                  settle_nxt = settle_cnt + 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge prog_clock or negedge global_resetn) begin
      if (!global_resetn) state <= IDLE;
      else                state <= state_nxt;
   end

   // Datapath and status registers; reset discards any load in progress.
   always_ff @(posedge prog_clock or negedge global_resetn) begin
      if (!global_resetn) begin
         ccff_head     <= '0;
         ccff_shift_en <= 1'b0;
         cfg_done      <= 1'b0;
         cfg_err       <= 1'b0;
         word_count    <= '0;
         stall_cnt     <= '0;
         settle_cnt    <= '0;
`ifdef CCFF_LOADER_CRC_EN
         crc           <= 16'hFFFF;
`endif
      end else begin
         ccff_head     <= head_nxt;
         ccff_shift_en <= shift_nxt;
         cfg_done      <= done_nxt;
         cfg_err       <= err_nxt;
         word_count    <= wc_nxt;
         stall_cnt     <= stall_nxt;
         settle_cnt    <= settle_nxt;
`ifdef CCFF_LOADER_CRC_EN
         crc           <= crc_nxt;
`endif
      end
   end

endmodule
